instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder. Generates sequential 32-bit fetch addresses and issues single-outstanding requests to instruction memory.
- Buffers returned words with their PCs in a small FIFO and presents them to the decoder through a valid/ready handshake.
- Handles branch/jump/call redirects from execute, including discarding an in-flight stale fetch.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >= 2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  fetch request valid.
- mem_addr  out  ADDR_WIDTH  word-aligned fetch address.
- mem_ack  in  1  one-cycle pulse: mem_rdata valid, request complete.
- mem_rdata  in  32  fetched instruction word.
- redirect_valid  in  1  one-cycle pulse from execute: control-flow change.
- redirect_pc  in  ADDR_WIDTH  new fetch target.
- out_valid  out  1  out_instr/out_pc valid toward the decoder.
- out_instr  out  32  instruction word (drives the decoder instruction input).
- out_pc  out  ADDR_WIDTH  address of out_instr.
- out_ready  in  1  decode stage accepts this cycle (low while the pipeline stalls).

Behaviour:
- Reset (rst=1 at an edge):
  - mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
  - FIFO empty, fetch_pc=RESET_PC, FSM=IDLE.
  - Reset mid-request abandons the request. Any mem_ack arriving after reset is ignored until the first new request is issued.
- FSM states:
  - IDLE: no request outstanding.
  - BUSY: request outstanding, data wanted.
  - DISCARD: request outstanding, data stale.
- Request issue:
  - In IDLE, issue when (fifo_count + 0) < FIFO_DEPTH, using registered count.
  - Issue sets mem_req=1 and mem_addr=fetch_pc, then goes to BUSY.
  - mem_req and mem_addr stay constant until the mem_ack cycle.
  - Only one request may be outstanding.
  - First request after reset: mem_req=1 in the first cycle with rst=0.
- Ack in BUSY (no redirect):
  - Push {fetch_pc, mem_rdata} into the FIFO and set fetch_pc+=4 (wraps mod 2^ADDR_WIDTH).
  - Go to IDLE, or issue the next request in the same cycle (back-to-back, stay BUSY) if space remains after the push, counting a same-cycle pop.
- Data latency: mem_ack at cycle N -> out_valid=1 with that word at N+1 when the FIFO was empty.
- Output handshake:
  - out_valid = FIFO non-empty; out_instr/out_pc show the FIFO head.
  - Pop when out_valid && out_ready.
  - Head must stay stable while out_valid && !out_ready.
  - Push and pop in the same cycle are both honoured; count stays unchanged.
- Full: with fifo_count==FIFO_DEPTH, no request is issued and mem_req stays 0. Fetch resumes the cycle after a pop frees an entry.
- Redirect (highest priority):
  - FIFO is flushed that edge; out_valid=0 next cycle.
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - A same-cycle pop or push is dropped.
  - IDLE: next state issues at the new PC, so mem_req=1, mem_addr=target in the following cycle.
  - BUSY with mem_ack that same cycle: data dropped, behaves as IDLE.
  - BUSY without mem_ack: go to DISCARD. mem_req stays high with the old address, since a request is never withdrawn.
  - DISCARD: on mem_ack, drop data and go to IDLE, which issues the redirect target next cycle. A further redirect while in DISCARD only updates fetch_pc.
- Misaligned redirect_pc low bits are silently cleared; no exception is raised.

Test Plan:
- Reset release, mem_ack always 1 cycle after each req, out_ready=1 -> addresses 0x0, 0x4, 0x8 fetched. out_pc/out_instr match 0x0/word0 one cycle after the first ack.
- out_ready=0 for 10 cycles -> exactly 2 words buffered (0x0, 0x4) and mem_req=0 once full. Head stays 0x0 stable. Raising out_ready resumes fetch at 0x8.
- Redirect to 0x100 in IDLE with 2 words buffered -> out_valid=0 next cycle, next mem_addr=0x100, first out_pc=0x100.
- Redirect to 0x200 while a request to 0x8 is outstanding, ack 3 cycles later -> the 0x8 data is never presented and the next request is 0x200.
- Redirect coincident with mem_ack for 0x4 -> 0x4 dropped; next request is to the target.
- Redirect to 0x1003 -> fetch at 0x1000. Reset asserted while BUSY -> mem_req=0 next cycle and a late ack is ignored. fetch_pc at 0xFFFF_FFFC wraps to 0x0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding sequential fetch into a small PC+word FIFO
// feeding the decoder, with execute redirects that flush the FIFO and squash a stale fetch.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [31:0]           i_mem_rdata,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_out_valid,
    output logic [31:0]           o_out_instr,
    output logic [ADDR_WIDTH-1:0] o_out_pc,
    input  logic                  i_out_ready,
    output logic [1:0]            o_dbg_state
);

    localparam int                    PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                    CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_M = ~ADDR_WIDTH'(3);

    // Handshakes: o_mem_req/o_mem_addr hold from issue until the i_mem_ack cycle;
    // a FIFO entry transfers to decode on any edge where o_out_valid && i_out_ready.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_inc;
    logic [ADDR_WIDTH-1:0] w_redirect_target;
    logic [ADDR_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]           r_fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_after;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_room_idle;
    logic                  w_room_after;

    assign w_fetch_pc_inc    = r_fetch_pc + PC_STEP;
    assign w_redirect_target = i_redirect_pc & ALIGN_M;

    // A redirect drops any same-cycle push or pop; the FIFO is flushed instead.
    assign o_out_valid   = (r_count != '0);
    assign w_pop         = o_out_valid && i_out_ready && !i_redirect_valid;
    assign w_push        = (r_state == S_BUSY) && i_mem_ack && !i_redirect_valid;
    assign w_count_after = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_room_idle   = (r_count < DEPTH_C);
    assign w_room_after  = (w_count_after < DEPTH_C);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!i_redirect_valid && w_room_idle) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (i_redirect_valid) begin
                    w_next_state = i_mem_ack ? S_IDLE : S_DISCARD;
                end else if (i_mem_ack) begin
                    w_next_state = w_room_after ? S_BUSY : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (i_mem_ack) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_req   = (r_state != S_IDLE);
        o_dbg_state = r_state;
    end

    // Issue from IDLE uses fetch_pc; a back-to-back issue uses the PC after the pushed word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
        end else begin
            if (i_redirect_valid) begin
                r_fetch_pc <= w_redirect_target;
            end else if (w_push) begin
                r_fetch_pc <= w_fetch_pc_inc;
            end
            if (r_state == S_IDLE && w_next_state == S_BUSY) begin
                r_mem_addr <= r_fetch_pc;
            end else if (w_push && w_next_state == S_BUSY) begin
                r_mem_addr <= w_fetch_pc_inc;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_after;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
            r_fifo_instr[r_wr_ptr] <= i_mem_rdata;
        end
    end

    // Outputs read zero while empty so a flushed head never leaks toward decode.
    assign o_out_instr = o_out_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign o_out_pc    = o_out_valid ? r_fifo_pc[r_rd_ptr] : '0;
    assign o_mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory responder plus a transaction-level model of the
// fetch stream (expected request addresses and the ordered words owed to decode).
module tb_instr_fetch_unit;

    localparam int          AW     = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic          i_mem_ack;
    logic [31:0]   i_mem_rdata;
    logic          i_redirect_valid;
    logic [AW-1:0] i_redirect_pc;
    logic          o_out_valid;
    logic [31:0]   o_out_instr;
    logic [AW-1:0] o_out_pc;
    logic          i_out_ready;
    logic [1:0]    o_dbg_state;

    instr_fetch_unit #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .o_mem_req       (o_mem_req),
        .o_mem_addr      (o_mem_addr),
        .i_mem_ack       (i_mem_ack),
        .i_mem_rdata     (i_mem_rdata),
        .i_redirect_valid(i_redirect_valid),
        .i_redirect_pc   (i_redirect_pc),
        .o_out_valid     (o_out_valid),
        .o_out_instr     (o_out_instr),
        .o_out_pc        (o_out_pc),
        .i_out_ready     (i_out_ready),
        .o_dbg_state     (o_dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: words owed to decode in order, next address memory should see.
    logic [31:0] exp_q   [$];
    logic [31:0] pop_log [$];
    logic [31:0] req_log [$];
    logic [31:0] exp_next_req;
    logic [31:0] req_addr;
    bit          mem_out;
    bit          stale;
    bit          want_prev;
    int          mem_wait;

    int          lat_min = 1;
    int          lat_max = 1;
    bit          slow_en;
    logic [31:0] slow_addr;
    int          slow_lat;
    bit          drv_ready = 1'b1;
    bit          rand_ready;
    bit          rand_redir;
    bit          pend_redir;
    logic [31:0] pend_tgt;
    bit          ack_redir_en;
    logic [31:0] ack_redir_addr;
    logic [31:0] ack_redir_tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pop_log.delete();
        req_log.delete();
        exp_next_req = RST_PC;
        mem_out      = 1'b0;
        stale        = 1'b0;
        want_prev    = 1'b0;
        mem_wait     = 0;
    endtask

    // One clock: check outputs against the model, act as memory, drive, advance the model.
    task automatic tick();
        bit          ack;
        bit          redir;
        bit          pop;
        bit          want;
        bit          ready;
        logic [31:0] tgt;
        checks++;
        if (o_out_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL out_valid: got %b expected %b", o_out_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            checks++;
            if (o_out_pc !== exp_q[0] || o_out_instr !== mem_word(exp_q[0])) begin
                failures++;
                $display("FAIL head: got pc=%h instr=%h expected pc=%h instr=%h",
                         o_out_pc, o_out_instr, exp_q[0], mem_word(exp_q[0]));
            end
        end
        if (want_prev) begin
            checks++;
            if (o_mem_req !== 1'b1) begin
                failures++;
                $display("FAIL issue: mem_req=%b expected 1", o_mem_req);
            end
        end
        if (exp_q.size() == DEPTH) begin
            checks++;
            if (o_mem_req !== 1'b0) begin
                failures++;
                $display("FAIL full_no_req: mem_req=%b expected 0", o_mem_req);
            end
        end
        if (mem_out) begin
            checks++;
            if (o_mem_req !== 1'b1 || o_mem_addr !== req_addr) begin
                failures++;
                $display("FAIL req_hold: req=%b addr=%h expected req=1 addr=%h",
                         o_mem_req, o_mem_addr, req_addr);
            end
        end else if (o_mem_req === 1'b1) begin
            mem_out  = 1'b1;
            req_addr = o_mem_addr;
            req_log.push_back(o_mem_addr);
            checks++;
            if (o_mem_addr !== exp_next_req) begin
                failures++;
                $display("FAIL req_addr: got %h expected %h", o_mem_addr, exp_next_req);
            end
            mem_wait = (slow_en && req_addr == slow_addr) ? slow_lat
                                                          : int'($urandom_range(lat_max, lat_min));
        end

        ack = mem_out && (mem_wait == 0);
        if (mem_out && mem_wait > 0) mem_wait--;
        tgt   = $urandom();
        redir = 1'b0;
        if (pend_redir) begin
            redir = 1'b1;
            tgt   = pend_tgt;
        end else if (ack_redir_en && ack && req_addr == ack_redir_addr) begin
            redir        = 1'b1;
            tgt          = ack_redir_tgt;
            ack_redir_en = 1'b0;
        end else if (rand_redir && $urandom_range(19, 0) == 0) begin
            redir = 1'b1;
        end
        ready = rand_ready ? ($urandom_range(3, 0) != 0) : drv_ready;

        i_mem_ack        = ack;
        i_mem_rdata      = ack ? mem_word(req_addr) : $urandom();
        i_redirect_valid = redir;
        i_redirect_pc    = tgt;
        i_out_ready      = ready;
        pop  = (exp_q.size() != 0) && ready && !redir;
        want = !mem_out && (exp_q.size() < DEPTH) && !redir;

        @(posedge clk);
        if (pop) pop_log.push_back(exp_q.pop_front());
        if (ack) begin
            mem_out = 1'b0;
            if (!stale && !redir) begin
                exp_q.push_back(req_addr);
                exp_next_req = req_addr + 32'd4;
            end
            stale = 1'b0;
        end
        if (redir) begin
            exp_q.delete();
            exp_next_req = {tgt[31:2], 2'b00};
            stale        = mem_out;
        end
        pend_redir = 1'b0;
        want_prev  = want;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        i_mem_ack        = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_mem_rdata      = '0;
        i_out_ready      = 1'b0;
        slow_en          = 1'b0;
        ack_redir_en     = 1'b0;
        pend_redir       = 1'b0;
        rand_ready       = 1'b0;
        rand_redir       = 1'b0;
        lat_min          = 1;
        lat_max          = 1;
        drv_ready        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        want_prev = 1'b1;
    endtask

    task automatic run_until_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (pop_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (pop_log.size() < n) begin
            failures++;
            $display("FAIL %s_timeout: pops=%0d expected %0d", tag, pop_log.size(), n);
        end
    endtask

    task automatic run_until_reqs(input int n, input int budget, input string tag);
        int k = 0;
        while (req_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (req_log.size() < n) begin
            failures++;
            $display("FAIL %s_timeout: reqs=%0d expected %0d", tag, req_log.size(), n);
        end
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        i_mem_ack        = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_mem_rdata      = '0;
        i_out_ready      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_mem_req !== 1'b0 || o_mem_addr !== RST_PC || o_dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_req: req=%b addr=%h state=%0d expected 0/%h/0",
                     o_mem_req, o_mem_addr, o_dbg_state, RST_PC);
        end
        checks++;
        if (o_out_valid !== 1'b0 || o_out_instr !== 32'h0 || o_out_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_out: valid=%b instr=%h pc=%h expected 0/0/0",
                     o_out_valid, o_out_instr, o_out_pc);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== RST_PC) begin
            failures++;
            $display("FAIL first_req: req=%b addr=%h expected 1/%h", o_mem_req, o_mem_addr, RST_PC);
        end
        model_reset();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pcs [3] = '{32'h0, 32'h4, 32'h8};
        do_reset();
        run_until_pops(3, 40, "seq");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pop_log[i] !== exp_pcs[i]) begin
                failures++;
                $display("FAIL seq_pc%0d: got %h expected %h", i, pop_log[i], exp_pcs[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pcs [3] = '{32'h0, 32'h4, 32'h8};
        do_reset();
        drv_ready = 1'b0;
        repeat (10) tick();
        checks++;
        if (req_log.size() != 2 || o_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_full: reqs=%0d req=%b expected 2/0", req_log.size(), o_mem_req);
        end
        checks++;
        if (o_out_valid !== 1'b1 || o_out_pc !== 32'h0) begin
            failures++;
            $display("FAIL stall_head: valid=%b pc=%h expected 1/0", o_out_valid, o_out_pc);
        end
        drv_ready = 1'b1;
        run_until_pops(3, 40, "stall");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pop_log[i] !== exp_pcs[i]) begin
                failures++;
                $display("FAIL stall_pc%0d: got %h expected %h", i, pop_log[i], exp_pcs[i]);
            end
        end
    endtask

    task automatic test_redirect_idle();
        int n;
        do_reset();
        drv_ready = 1'b0;
        repeat (8) tick();
        pend_redir = 1'b1;
        pend_tgt   = 32'h100;
        tick();
        checks++;
        if (o_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_idle_flush: valid=%b expected 0", o_out_valid);
        end
        n = req_log.size();
        run_until_reqs(n + 1, 10, "redir_idle");
        checks++;
        if (req_log[n] !== 32'h100) begin
            failures++;
            $display("FAIL redir_idle_req: got %h expected 00000100", req_log[n]);
        end
        drv_ready = 1'b1;
        pop_log.delete();
        run_until_pops(1, 20, "redir_idle");
        checks++;
        if (pop_log[0] !== 32'h100) begin
            failures++;
            $display("FAIL redir_idle_pop: got %h expected 00000100", pop_log[0]);
        end
    endtask

    task automatic test_redirect_busy();
        int n;
        int k = 0;
        do_reset();
        slow_en   = 1'b1;
        slow_addr = 32'h8;
        slow_lat  = 3;
        while (!(mem_out && req_addr == 32'h8) && k < 30) begin
            tick();
            k++;
        end
        pend_redir = 1'b1;
        pend_tgt   = 32'h200;
        tick();
        checks++;
        if (o_dbg_state !== 2'd2 || o_mem_req !== 1'b1 || o_mem_addr !== 32'h8) begin
            failures++;
            $display("FAIL redir_busy_discard: state=%0d req=%b addr=%h expected 2/1/00000008",
                     o_dbg_state, o_mem_req, o_mem_addr);
        end
        n = req_log.size();
        run_until_reqs(n + 1, 20, "redir_busy");
        checks++;
        if (req_log[n] !== 32'h200) begin
            failures++;
            $display("FAIL redir_busy_req: got %h expected 00000200", req_log[n]);
        end
        repeat (8) tick();
        foreach (pop_log[i]) begin
            checks++;
            if (pop_log[i] === 32'h8) begin
                failures++;
                $display("FAIL redir_busy_stale: got %h presented, expected never", pop_log[i]);
            end
        end
        slow_en = 1'b0;
    endtask

    task automatic test_redirect_ack();
        int          idx = -1;
        logic [31:0] got;
        do_reset();
        ack_redir_en   = 1'b1;
        ack_redir_addr = 32'h4;
        ack_redir_tgt  = 32'h300;
        repeat (15) tick();
        foreach (req_log[i]) if (req_log[i] == 32'h4 && idx < 0) idx = i;
        got = (idx >= 0 && idx + 1 < req_log.size()) ? req_log[idx + 1] : 32'hFFFF_FFFF;
        checks++;
        if (got !== 32'h300) begin
            failures++;
            $display("FAIL redir_ack_req: got %h expected 00000300", got);
        end
        foreach (pop_log[i]) begin
            checks++;
            if (pop_log[i] === 32'h4) begin
                failures++;
                $display("FAIL redir_ack_drop: got %h presented, expected dropped", pop_log[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        int n;
        do_reset();
        repeat (3) tick();
        pend_redir = 1'b1;
        pend_tgt   = 32'h1003;
        tick();
        pop_log.delete();
        n = req_log.size();
        run_until_reqs(n + 1, 20, "misalign");
        checks++;
        if (req_log[n] !== 32'h1000) begin
            failures++;
            $display("FAIL misalign_req: got %h expected 00001000", req_log[n]);
        end
        run_until_pops(1, 20, "misalign");
        checks++;
        if (pop_log[0] !== 32'h1000) begin
            failures++;
            $display("FAIL misalign_pop: got %h expected 00001000", pop_log[0]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pcs [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        do_reset();
        pend_redir = 1'b1;
        pend_tgt   = 32'hFFFF_FFF8;
        tick();
        pop_log.delete();
        run_until_pops(3, 40, "wrap");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pop_log[i] !== exp_pcs[i]) begin
                failures++;
                $display("FAIL wrap_pc%0d: got %h expected %h", i, pop_log[i], exp_pcs[i]);
            end
        end
    endtask

    task automatic test_reset_busy();
        int k = 0;
        do_reset();
        slow_en   = 1'b1;
        slow_addr = 32'h4;
        slow_lat  = 3;
        while (!(mem_out && req_addr == 32'h4) && k < 30) begin
            tick();
            k++;
        end
        rst              = 1'b1;
        i_mem_ack        = 1'b0;
        i_redirect_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_mem_req !== 1'b0 || o_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy_req: req=%b valid=%b expected 0/0", o_mem_req, o_out_valid);
        end
        rst         = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        i_mem_ack = 1'b0;
        model_reset();
        slow_en = 1'b0;
        checks++;
        if (o_out_valid !== 1'b0 || o_mem_req !== 1'b1 || o_mem_addr !== RST_PC) begin
            failures++;
            $display("FAIL rst_busy_late_ack: valid=%b req=%b addr=%h expected 0/1/%h",
                     o_out_valid, o_mem_req, o_mem_addr, RST_PC);
        end
        run_until_pops(2, 30, "rst_busy");
        checks++;
        if (pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4) begin
            failures++;
            $display("FAIL rst_busy_resume: got %h,%h expected 00000000,00000004",
                     pop_log[0], pop_log[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        rand_ready = 1'b1;
        rand_redir = 1'b1;
        lat_min    = 0;
        lat_max    = 3;
        repeat (3000) tick();
        checks++;
        if (pop_log.size() < 100) begin
            failures++;
            $display("FAIL random_progress: pops=%0d expected at least 100", pop_log.size());
        end
        rand_ready = 1'b0;
        rand_redir = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        i_mem_ack        = 1'b0;
        i_mem_rdata      = '0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_out_ready      = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_idle();
        test_redirect_busy();
        test_redirect_ack();
        test_misaligned();
        test_wrap();
        test_reset_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
